// File: rtl/core_simple_pkg.sv
// Shared definitions for the simple-FU execute path: entry field layout and ALU opcodes.
package core_simple_pkg;

    // ALU opcodes, shared with decode.
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    // Entry layout, LSB first: aluop, rd, rs1_rdy, rs1_val, rs2_rdy, rs2_val, rfwrite.
    function automatic int ent_w(int xlen, int raw, int opw);
        return 1 + 2 * (xlen + 1) + raw + opw;
    endfunction

    function automatic int off_rd(int opw);
        return opw;
    endfunction

    function automatic int off_r1rdy(int raw, int opw);
        return opw + raw;
    endfunction

    function automatic int off_r1val(int raw, int opw);
        return opw + raw + 1;
    endfunction

    function automatic int off_r2rdy(int xlen, int raw, int opw);
        return opw + raw + 1 + xlen;
    endfunction

    function automatic int off_r2val(int xlen, int raw, int opw);
        return opw + raw + 2 + xlen;
    endfunction

    function automatic int off_rf(int xlen, int raw, int opw);
        return opw + raw + 2 + 2 * xlen;
    endfunction

    // Layout at the default widths (XLEN=32, RAW=5, OPW=5).
    localparam int ENTW_DEF = ent_w(32, 5, 5);

endpackage

// File: rtl/alu.sv
// Shared combinational ALU of the simple functional unit.
module alu
    import core_simple_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic [OPW-1:0]  aluop,
    output logic [XLEN-1:0] aluout
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = aluin2[SHW-1:0];

    // Opcode decode; unknown opcodes produce zero.
    always_comb begin
        aluout = '0;
        case (aluop)
            OPW'(ALU_ADD):  aluout = aluin1 + aluin2;
            OPW'(ALU_SUB):  aluout = aluin1 - aluin2;
            OPW'(ALU_AND):  aluout = aluin1 & aluin2;
            OPW'(ALU_OR):   aluout = aluin1 | aluin2;
            OPW'(ALU_XOR):  aluout = aluin1 ^ aluin2;
            OPW'(ALU_SLL):  aluout = aluin1 << shamt;
            OPW'(ALU_SRL):  aluout = aluin1 >> shamt;
            OPW'(ALU_SRA):  aluout = $signed(aluin1) >>> shamt;
            OPW'(ALU_SLT):  aluout = {{(XLEN-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            OPW'(ALU_SLTU): aluout = {{(XLEN-1){1'b0}}, (aluin1 < aluin2)};
            default:        aluout = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr (mod N).
module rr_arbiter #(
    parameter int N    = 2,
    parameter int PTRW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [PTRW-1:0] ptr,
    output logic [N-1:0]    gnt
);

    int  rank;
    int  best_rank;
    int  best;
    logic found;

    // Rank each requester by its distance from ptr; the closest one wins.
    always_comb begin
        rank      = 0;
        best_rank = N;
        best      = 0;
        found     = 1'b0;
        gnt       = '0;
        for (int i = 0; i < N; i++) begin
            rank = (i + N - int'(ptr)) % N;
            if (req[i] && (rank < best_rank)) begin
                best_rank = rank;
                best      = i;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = found && (best == i);
        end
    end

endmodule

// File: rtl/ex_simple_pipe.sv
// Registered simple-FU execute stage: round-robin issue from the RS, shared ALU,
// result register with valid/ready toward the ROB and a coincident RF write.
module ex_simple_pipe
    import core_simple_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RAW     = 5,
    parameter int OPW     = 5,
    parameter int NUM_ENT = 2,
    parameter int ENTW    = 1 + 2 * (XLEN + 1) + RAW + OPW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_ENT*ENTW-1:0] rs_entry,
    input  logic [NUM_ENT-1:0]      rs_busy,
    output logic [NUM_ENT-1:0]      rs_issue,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN+RAW-1:0]     out_data,
    output logic                    wr_en,
    output logic [RAW-1:0]          wr_addr,
    output logic [XLEN-1:0]         wr_data
);

    localparam int PTRW  = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int O_RD  = off_rd(OPW);
    localparam int O_R1R = off_r1rdy(RAW, OPW);
    localparam int O_R1V = off_r1val(RAW, OPW);
    localparam int O_R2R = off_r2rdy(XLEN, RAW, OPW);
    localparam int O_R2V = off_r2val(XLEN, RAW, OPW);
    localparam int O_RF  = off_rf(XLEN, RAW, OPW);

    logic [ENTW-1:0]    ent [NUM_ENT];
    logic [NUM_ENT-1:0] req;
    logic [NUM_ENT-1:0] gnt;
    logic               accept;
    logic               issue_en;

    logic [OPW-1:0]     sel_op;
    logic [RAW-1:0]     sel_rd;
    logic [XLEN-1:0]    sel_v1;
    logic [XLEN-1:0]    sel_v2;
    logic               sel_rf;
    logic [XLEN-1:0]    aluout;

    logic [PTRW-1:0]    ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic [RAW-1:0]     rd_q, rd_d;
    logic               rf_q, rf_d;

    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        assign ent[i] = rs_entry[i*ENTW +: ENTW];
        assign req[i] = rs_busy[i] & ent[i][O_R1R] & ent[i][O_R2R];
    end

    rr_arbiter #(.N(NUM_ENT), .PTRW(PTRW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Issue needs room in the result register, a candidate, no flush, and no reset.
    assign accept   = !valid_q || out_ready;
    assign issue_en = rst_n && accept && (|req) && !flush;
    assign rs_issue = issue_en ? gnt : '0;

    // AND-OR mux of the granted entry; all-zero ALU inputs when nothing issues.
    always_comb begin
        sel_op = '0;
        sel_rd = '0;
        sel_v1 = '0;
        sel_v2 = '0;
        sel_rf = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (rs_issue[i]) begin
                sel_op = sel_op | ent[i][OPW-1:0];
                sel_rd = sel_rd | ent[i][O_RD +: RAW];
                sel_v1 = sel_v1 | ent[i][O_R1V +: XLEN];
                sel_v2 = sel_v2 | ent[i][O_R2V +: XLEN];
                sel_rf = sel_rf | ent[i][O_RF];
            end
        end
    end

    alu #(.XLEN(XLEN), .OPW(OPW)) u_alu (
        .aluin1 (sel_v1),
        .aluin2 (sel_v2),
        .aluop  (sel_op),
        .aluout (aluout)
    );

    // Next state: pointer advances past the winner; result loads on issue, else drains/flushes.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        res_d   = res_q;
        rd_d    = rd_q;
        rf_d    = rf_q;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (rs_issue[i]) ptr_d = PTRW'((i + 1) % NUM_ENT);
        end
        if (issue_en) begin
            valid_d = 1'b1;
            res_d   = aluout;
            rd_d    = sel_rd;
            rf_d    = sel_rf;
        end else if (flush || (valid_q && out_ready)) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            rf_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            rf_q    <= rf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = {res_q, rd_q};
    assign wr_en     = valid_q && out_ready && rf_q && !flush;
    assign wr_addr   = rd_q;
    assign wr_data   = res_q;

endmodule

// File: tb/tb_ex_simple_pipe.sv
// Self-checking bench for ex_simple_pipe: directed scenarios with literal expectations
// plus a cycle-by-cycle reference model of the issue/result/write behaviour.
module tb_ex_simple_pipe;
    import core_simple_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int OPW  = 5;
    localparam int N    = 2;
    localparam int ENTW = 1 + 2 * (XLEN + 1) + RAW + OPW;

    logic                 clk;
    logic                 rst_n;
    logic [N*ENTW-1:0]    rs_entry;
    logic [N-1:0]         rs_busy;
    logic [N-1:0]         rs_issue;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN+RAW-1:0]  out_data;
    logic                 wr_en;
    logic [RAW-1:0]       wr_addr;
    logic [XLEN-1:0]      wr_data;

    ex_simple_pipe #(.XLEN(XLEN), .RAW(RAW), .OPW(OPW), .NUM_ENT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_entry  (rs_entry),
        .rs_busy   (rs_busy),
        .rs_issue  (rs_issue),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ENTW-1:0] mk(input int op, input int rd, input logic [31:0] a,
                                            input logic [31:0] b, input logic rf);
        logic [4:0] o5;
        logic [4:0] r5;
        o5 = 5'(op);
        r5 = 5'(rd);
        return {rf, b, 1'b1, a, 1'b1, r5, o5};
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'($signed(a) >>> sh);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // Reference model state: who is next in line, and what the result register holds.
    int          m_ptr, n_ptr;
    bit          m_v, n_v;
    logic [31:0] m_res, n_res;
    logic [4:0]  m_rd, n_rd;
    bit          m_rf, n_rf;

    logic [ENTW-1:0] e;
    logic [N-1:0]    exp_issue;
    int              g;
    bit              cand;

    // At every falling edge compare all outputs with the model and work out the model's next state.
    always @(negedge clk) begin
        exp_issue = '0;
        cand = 1'b0;
        g = 0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                e = rs_entry[idx*ENTW +: ENTW];
                if (!cand && rs_busy[idx] && e[10] && e[43]) begin
                    cand = 1'b1;
                    g = idx;
                end
            end
            if (cand && (!m_v || out_ready) && !flush) exp_issue[g] = 1'b1;
        end
        chk("m_rs_issue", 64'(rs_issue), 64'(exp_issue));
        chk("m_out_valid", 64'(out_valid), 64'(m_v));
        chk("m_out_data", 64'(out_data), 64'({m_res, m_rd}));
        chk("m_wr_en", 64'(wr_en), 64'(rst_n && m_v && out_ready && m_rf && !flush));
        chk("m_wr_addr", 64'(wr_addr), 64'(m_rd));
        chk("m_wr_data", 64'(wr_data), 64'(m_res));
        n_ptr = m_ptr; n_v = m_v; n_res = m_res; n_rd = m_rd; n_rf = m_rf;
        if (!rst_n) begin
            n_ptr = 0; n_v = 1'b0; n_res = '0; n_rd = '0; n_rf = 1'b0;
        end else if (exp_issue != '0) begin
            e = rs_entry[g*ENTW +: ENTW];
            n_v   = 1'b1;
            n_res = alu_ref(int'(e[4:0]), e[42:11], e[75:44]);
            n_rd  = e[9:5];
            n_rf  = e[76];
            n_ptr = (g + 1) % N;
        end else if (flush || (m_v && out_ready)) begin
            n_v = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_v <= 1'b0; m_res <= '0; m_rd <= '0; m_rf <= 1'b0;
        end else begin
            m_ptr <= n_ptr; m_v <= n_v; m_res <= n_res; m_rd <= n_rd; m_rf <= n_rf;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int ops [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                     ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};

    initial begin
        rst_n     = 1'b0;
        rs_entry  = '0;
        rs_busy   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset: eligible entry must not be granted, outputs cleared.
        rs_entry[0 +: ENTW] = mk(ALU_ADD, 3, 32'd5, 32'd7, 1'b1);
        rs_busy = 2'b01;
        #2;
        chk("rst_rs_issue", 64'(rs_issue), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single ADD 5+7 -> rd 3.
        #1;
        chk("add_issue", 64'(rs_issue), 64'd1);
        tick();
        rs_busy = 2'b00;
        #1;
        chk("add_data", 64'(out_data), 64'({32'd12, 5'd3}));
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_wr_en", 64'(wr_en), 64'd1);
        chk("add_wr_addr", 64'(wr_addr), 64'd3);
        chk("add_wr_data", 64'(wr_data), 64'd12);

        // Round robin with both eligible every cycle; entry0 writes rd 0.
        do_reset();
        rs_entry[0 +: ENTW]    = mk(ALU_ADD, 0, 32'd1, 32'd1, 1'b1);
        rs_entry[ENTW +: ENTW] = mk(ALU_ADD, 2, 32'd2, 32'd2, 1'b1);
        rs_busy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 64'(rs_issue), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k > 0) chk("rr_data", 64'(out_data),
                           (k % 2 == 1) ? 64'({32'd2, 5'd0}) : 64'({32'd4, 5'd2}));
            if (k == 1) chk("rd0_wr_en", 64'(wr_en), 64'd1);
            tick();
        end

        // Backpressure: hold {4,2} for three cycles with entry1 waiting.
        out_ready = 1'b0;
        rs_busy = 2'b10;
        rs_entry[ENTW +: ENTW] = mk(ALU_ADD, 5, 32'd10, 32'd20, 1'b1);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("hold_issue", 64'(rs_issue), 64'd0);
            chk("hold_data", 64'(out_data), 64'({32'd4, 5'd2}));
            chk("hold_wr_en", 64'(wr_en), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("drain_wr_en", 64'(wr_en), 64'd1);
        chk("drain_issue", 64'(rs_issue), 64'd2);
        tick();
        #1;
        chk("drain_data", 64'(out_data), 64'({32'd30, 5'd5}));
        chk("drain_valid", 64'(out_valid), 64'd1);

        // Flush with a valid result being accepted.
        flush = 1'b1;
        rs_busy = 2'b11;
        #1;
        chk("flush_wr_en", 64'(wr_en), 64'd0);
        chk("flush_issue", 64'(rs_issue), 64'd0);
        tick();
        flush = 1'b0;
        rs_busy = 2'b00;
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);

        // Sweep the opcodes through entry0; the model checks every cycle.
        rs_busy = 2'b01;
        for (int j = 0; j < 10; j++) begin
            rs_entry[0 +: ENTW] = mk(ops[j], j + 1, 32'hF000_0013 + 32'(j * 7), 32'(j + 3), 1'b1);
            tick();
        end
        rs_busy = 2'b00;
        tick();

        // SUB 9-4 with rfwrite=0: result shows, no write.
        rs_entry[0 +: ENTW] = mk(ALU_SUB, 7, 32'd9, 32'd4, 1'b0);
        rs_busy = 2'b01;
        #1;
        chk("sub_issue", 64'(rs_issue), 64'd1);
        tick();
        rs_busy = 2'b00;
        #1;
        chk("sub_data", 64'(out_data), 64'({32'd5, 5'd7}));
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_wr_en", 64'(wr_en), 64'd0);
        tick();

        // Async reset in the middle of a hold; pointer must restart at entry0.
        rs_entry[0 +: ENTW] = mk(ALU_ADD, 6, 32'd3, 32'd4, 1'b1);
        rs_busy = 2'b01;
        tick();
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_wr_en", 64'(wr_en), 64'd0);
        chk("arst_issue", 64'(rs_issue), 64'd0);
        tick();
        rs_busy = 2'b11;
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("arst_first_grant", 64'(rs_issue), 64'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
